// File: rtl/scan_top_if.sv
// Host write port of the scan-chain writer. The host side uses the master modport.
// The writer side uses the slave modport.
interface scan_top_if #(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169
);
    logic                    write_valid;
    logic                    write_ready;
    logic                    write_reset;
    logic [ADDR_BITS-1:0]    write_addr;
    logic [PAYLOAD_BITS-1:0] write_payload;

    modport master (
        output write_valid,
        output write_reset,
        output write_addr,
        output write_payload,
        input  write_ready
    );

    modport slave (
        input  write_valid,
        input  write_reset,
        input  write_addr,
        input  write_payload,
        output write_ready
    );
endinterface

// File: rtl/scan_top.sv
// Scan-chain writer (host side) and the on-chip chain with OSC / RF_ANLG / SUPPLY
// config latches, all in the clk domain.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | write_ready=1, waiting for a host transaction
// S_RST   | scan_en and scan_reset held high for 2*CLOCKS_PER_SCAN_CLK cycles
// S_SHIFT | frame {addr,payload} serialised MSB first, one bit per scan_clk period
// S_LATCH | scan_en low for one cycle so the chain latches the addressed domain
module scan_top #(
    parameter int CLOCK_FREQ          = 20,
    parameter int CLOCKS_PER_SCAN_CLK = 5,
    parameter int ADDR_BITS           = 12,
    parameter int PAYLOAD_BITS        = 169
) (
    input  logic         i_clk,
    input  logic         i_reset,
    scan_top_if.slave    s_wr,
    output logic         o_scan_clk,
    output logic         o_scan_en,
    output logic         o_scan_in,
    output logic         o_scan_reset,
    output logic         o_scan_out,
    output logic [52:0]  o_osc_cfg,
    output logic [168:0] o_rf_cfg,
    output logic [19:0]  o_supply_cfg
);
    localparam int N     = ADDR_BITS + PAYLOAD_BITS;
    localparam int C     = CLOCKS_PER_SCAN_CLK;
    localparam int BIT_W = $clog2(N);
    localparam int TMR_W = $clog2(2 * C);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RST   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    if (PAYLOAD_BITS < 169 || CLOCKS_PER_SCAN_CLK < 2 || CLOCK_FREQ < 1) begin : g_param_check
        $error("scan_top: unsupported parameter set");
    end

    logic [1:0]       r_state;
    logic             r_start;
    logic [TMR_W-1:0] r_tmr;
    logic [BIT_W-1:0] r_bit;
    logic [N-1:0]     r_frame;
    logic             r_scan_clk;
    logic             r_scan_en;
    logic             r_scan_in;
    logic             r_scan_reset;

    logic [N-1:0]     r_sreg;
    logic             r_sclk_d;
    logic             r_sen_d;
    logic             r_srst_d;
    logic [52:0]      r_osc_cfg;
    logic [168:0]     r_rf_cfg;
    logic [19:0]      r_supply_cfg;

    logic [ADDR_BITS-1:0] w_chain_addr;
    logic                 w_latch;
    logic                 w_shift;

    assign s_wr.write_ready = (r_state == S_IDLE);

    // r_start marks the first cycle after accept; outputs move on the edge after it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_tmr        <= '0;
            r_bit        <= '0;
            r_frame      <= '0;
            r_scan_clk   <= 1'b0;
            r_scan_en    <= 1'b0;
            r_scan_in    <= 1'b0;
            r_scan_reset <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_wr.write_valid) begin
                        r_frame <= {s_wr.write_addr, s_wr.write_payload};
                        r_state <= s_wr.write_reset ? S_RST : S_SHIFT;
                        r_start <= 1'b1;
                    end
                end
                S_RST: begin
                    if (r_start) begin
                        r_start      <= 1'b0;
                        r_scan_en    <= 1'b1;
                        r_scan_reset <= 1'b1;
                        r_tmr        <= TMR_W'(2 * C - 1);
                    end else if (r_tmr == '0) begin
                        r_scan_en    <= 1'b0;
                        r_scan_reset <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_start) begin
                        r_start    <= 1'b0;
                        r_scan_en  <= 1'b1;
                        r_scan_clk <= 1'b0;
                        r_scan_in  <= r_frame[N-1];
                        r_bit      <= BIT_W'(N - 1);
                        r_tmr      <= TMR_W'(C - 1);
                    end else if (r_tmr == '0) begin
                        r_scan_clk <= 1'b0;
                        if (r_bit == '0) begin
                            r_scan_en <= 1'b0;
                            r_state   <= S_LATCH;
                        end else begin
                            r_bit     <= r_bit - 1'b1;
                            r_tmr     <= TMR_W'(C - 1);
                            r_scan_in <= r_frame[r_bit - 1'b1];
                        end
                    end else begin
                        // low for floor(C/2) cycles of the period, high for the rest
                        r_tmr      <= r_tmr - 1'b1;
                        r_scan_clk <= (r_tmr <= TMR_W'(C - C / 2));
                    end
                end
                S_LATCH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_chain_addr = r_sreg[N-1 -: ADDR_BITS];
    assign w_shift      = r_scan_clk && !r_sclk_d && r_scan_en;
    // The end of a reset strobe also drops scan_en; it must not look like a latch.
    assign w_latch      = r_sen_d && !r_scan_en && !r_srst_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sreg       <= '0;
            r_sclk_d     <= 1'b0;
            r_sen_d      <= 1'b0;
            r_srst_d     <= 1'b0;
            r_osc_cfg    <= '0;
            r_rf_cfg     <= '0;
            r_supply_cfg <= '0;
        end else begin
            r_sclk_d <= r_scan_clk;
            r_sen_d  <= r_scan_en;
            r_srst_d <= r_scan_reset;
            if (r_scan_reset) begin
                r_sreg       <= '0;
                r_osc_cfg    <= '0;
                r_rf_cfg     <= '0;
                r_supply_cfg <= '0;
            end else begin
                if (w_shift) begin
                    r_sreg <= {r_sreg[N-2:0], r_scan_in};
                end
                if (w_latch) begin
                    if (w_chain_addr == ADDR_BITS'(1)) begin
                        r_osc_cfg <= r_sreg[52:0];
                    end else if (w_chain_addr == ADDR_BITS'(2)) begin
                        r_rf_cfg <= r_sreg[168:0];
                    end else if (w_chain_addr == ADDR_BITS'(3)) begin
                        r_supply_cfg <= r_sreg[19:0];
                    end
                end
            end
        end
    end

    assign o_scan_clk   = r_scan_clk;
    assign o_scan_en    = r_scan_en;
    assign o_scan_in    = r_scan_in;
    assign o_scan_reset = r_scan_reset;
    assign o_scan_out   = r_sreg[N-1];
    assign o_osc_cfg    = r_osc_cfg;
    assign o_rf_cfg     = r_rf_cfg;
    assign o_supply_cfg = r_supply_cfg;
endmodule

// File: tb/tb_scan_top.sv
// Self-checking bench for scan_top: randomized host writes checked against a
// domain-level model of the three config latches and the serial frame timing.
module tb_scan_top;
    localparam int C  = 5;
    localparam int AB = 12;
    localparam int PB = 169;
    localparam int N  = AB + PB;
    localparam int LAT_SHIFT = N * C + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         o_scan_clk, o_scan_en, o_scan_in, o_scan_reset, o_scan_out;
    logic [52:0]  o_osc_cfg;
    logic [168:0] o_rf_cfg;
    logic [19:0]  o_supply_cfg;

    scan_top_if #(.ADDR_BITS(AB), .PAYLOAD_BITS(PB)) wr();

    scan_top #(
        .CLOCK_FREQ(20), .CLOCKS_PER_SCAN_CLK(C), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)
    ) u_dut (
        .i_clk(clk), .i_reset(rst), .s_wr(wr),
        .o_scan_clk(o_scan_clk), .o_scan_en(o_scan_en), .o_scan_in(o_scan_in),
        .o_scan_reset(o_scan_reset), .o_scan_out(o_scan_out),
        .o_osc_cfg(o_osc_cfg), .o_rf_cfg(o_rf_cfg), .o_supply_cfg(o_supply_cfg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [52:0]  m_osc;
    logic [168:0] m_rf;
    logic [19:0]  m_sup;

    function automatic logic [168:0] rand_pl();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[168:0];
    endfunction

    function automatic void model_write(input bit rt, input logic [11:0] a, input logic [168:0] p);
        if (rt) begin
            m_osc = '0; m_rf = '0; m_sup = '0;
        end else if (a == 12'd1) m_osc = p[52:0];
        else if (a == 12'd2) m_rf = p;
        else if (a == 12'd3) m_sup = p[19:0];
    endfunction

    // Drives one transaction and measures it; returns cycles from accept edge to
    // write_ready, count of waveform-rule violations, scan_clk rises and reset-strobe stats.
    task automatic do_write(input bit rt, input logic [11:0] a, input logic [168:0] p,
                            input bit hold, output int lat, output int bad,
                            output int rises, output int hi_cnt, output int first_hi);
        logic [N-1:0] f;
        bit prev_clk;
        int cyc;
        int bidx;
        f = {a, p};
        wr.write_valid = 1'b1; wr.write_reset = rt; wr.write_addr = a; wr.write_payload = p;
        @(posedge clk);
        lat = -1; bad = 0; rises = 0; hi_cnt = 0; first_hi = -1; prev_clk = 1'b0; cyc = 0;
        @(negedge clk);
        if (!hold) wr.write_valid = 1'b0;
        wr.write_reset = 1'($urandom); wr.write_addr = 12'($urandom); wr.write_payload = rand_pl();
        if (o_scan_en || o_scan_reset || o_scan_clk || wr.write_ready) bad++;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (wr.write_ready) begin
                lat = cyc;
                break;
            end
            if (rt) begin
                if (o_scan_clk || (o_scan_en !== o_scan_reset)) bad++;
                if (o_scan_en) begin
                    hi_cnt++;
                    if (first_hi < 0) first_hi = cyc;
                end
            end else begin
                if (o_scan_reset) bad++;
                if (cyc <= N * C) begin
                    bidx = N - 1 - (cyc - 1) / C;
                    if (!o_scan_en) bad++;
                    if (o_scan_clk !== (((cyc - 1) % C) >= C / 2)) bad++;
                    if (o_scan_in !== f[bidx]) bad++;
                end else if (o_scan_en || o_scan_clk) bad++;
                if (o_scan_clk && !prev_clk) rises++;
                prev_clk = o_scan_clk;
            end
        end
        if (o_scan_en || o_scan_reset) bad++;
        wr.write_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr.write_valid = 1'b0; wr.write_reset = 1'b0;
        wr.write_addr = '0; wr.write_payload = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_osc = '0; m_rf = '0; m_sup = '0;
        n_checks++; if (wr.write_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", wr.write_ready); else n_pass++;
        n_checks++; if ({o_scan_clk, o_scan_en, o_scan_in, o_scan_reset, o_scan_out} !== 5'b0)
            $display("FAIL reset_scan_pins got %b want 00000", {o_scan_clk, o_scan_en, o_scan_in, o_scan_reset, o_scan_out});
        else n_pass++;
        n_checks++; if ({o_osc_cfg, o_rf_cfg, o_supply_cfg} !== '0) $display("FAIL reset_cfg got nonzero want 0"); else n_pass++;
    endtask

    task automatic test_reset_txn();
        int lat, bad, rises, hi, fh;
        do_write(1'b1, 12'($urandom), rand_pl(), 1'b0, lat, bad, rises, hi, fh);
        model_write(1'b1, '0, '0);
        n_checks++; if (lat < 0) $display("FAIL rst_txn_timeout ready never rose"); else n_pass++;
        n_checks++; if (fh !== 1) $display("FAIL rst_txn_start got cycle %0d want 1", fh); else n_pass++;
        n_checks++; if (hi !== 2 * C) $display("FAIL rst_txn_width got %0d want %0d", hi, 2 * C); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL rst_txn_shape got %0d violations want 0", bad); else n_pass++;
        n_checks++; if ({o_osc_cfg, o_rf_cfg, o_supply_cfg} !== '0) $display("FAIL rst_txn_cfg got nonzero want 0"); else n_pass++;
    endtask

    task automatic test_supply();
        int lat, bad, rises, hi, fh;
        logic [168:0] p;
        p = 169'hABCDE;
        do_write(1'b0, 12'd3, p, 1'b0, lat, bad, rises, hi, fh);
        model_write(1'b0, 12'd3, p);
        n_checks++; if (lat !== LAT_SHIFT) $display("FAIL supply_latency got %0d want %0d", lat, LAT_SHIFT); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL supply_waveform got %0d violations want 0", bad); else n_pass++;
        n_checks++; if (rises !== N) $display("FAIL supply_rises got %0d want %0d", rises, N); else n_pass++;
        n_checks++; if (o_supply_cfg !== 20'hABCDE) $display("FAIL supply_cfg got %h want abcde", o_supply_cfg); else n_pass++;
        n_checks++; if (o_osc_cfg !== m_osc) $display("FAIL supply_osc_held got %h want %h", o_osc_cfg, m_osc); else n_pass++;
        n_checks++; if (o_rf_cfg !== m_rf) $display("FAIL supply_rf_held got %h want %h", o_rf_cfg, m_rf); else n_pass++;
    endtask

    task automatic test_osc_hold();
        int lat, bad, rises, hi, fh;
        logic [168:0] p;
        int idle;
        p = rand_pl();
        do_write(1'b0, 12'd1, p, 1'b0, lat, bad, rises, hi, fh);
        model_write(1'b0, 12'd1, p);
        n_checks++; if (o_osc_cfg !== m_osc) $display("FAIL osc_cfg got %h want %h", o_osc_cfg, m_osc); else n_pass++;
        idle = int'($urandom_range(0, 255));
        repeat (idle) @(negedge clk);
        n_checks++; if (o_osc_cfg !== m_osc) $display("FAIL osc_hold got %h want %h after %0d", o_osc_cfg, m_osc, idle); else n_pass++;
        n_checks++; if (o_supply_cfg !== m_sup) $display("FAIL osc_sup_held got %h want %h", o_supply_cfg, m_sup); else n_pass++;
        n_checks++; if (wr.write_ready !== 1'b1) $display("FAIL osc_idle_ready got %b want 1", wr.write_ready); else n_pass++;
    endtask

    task automatic test_rf();
        int lat, bad, rises, hi, fh;
        logic [191:0] t;
        logic [168:0] p;
        for (int k = 0; k < 2; k++) begin
            t = (k == 0) ? {192{1'b1}} : {48{4'h5}};
            p = t[168:0];
            do_write(1'b0, 12'd2, p, 1'b0, lat, bad, rises, hi, fh);
            model_write(1'b0, 12'd2, p);
            n_checks++; if (lat !== LAT_SHIFT) $display("FAIL rf_latency%0d got %0d want %0d", k, lat, LAT_SHIFT); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL rf_waveform%0d got %0d violations want 0", k, bad); else n_pass++;
            n_checks++; if (o_rf_cfg !== m_rf) $display("FAIL rf_cfg%0d got %h want %h", k, o_rf_cfg, m_rf); else n_pass++;
            n_checks++; if (o_osc_cfg !== m_osc) $display("FAIL rf_osc_held%0d got %h want %h", k, o_osc_cfg, m_osc); else n_pass++;
        end
    endtask

    task automatic test_bad_addr_busy();
        int lat, bad, rises, hi, fh;
        int low_ready;
        do_write(1'b0, 12'd7, rand_pl(), 1'b1, lat, bad, rises, hi, fh);
        n_checks++; if (lat !== LAT_SHIFT) $display("FAIL busy_latency got %0d want %0d", lat, LAT_SHIFT); else n_pass++;
        n_checks++; if ({o_osc_cfg, o_rf_cfg, o_supply_cfg} !== {m_osc, m_rf, m_sup})
            $display("FAIL addr7_cfg got %h/%h want %h/%h", o_osc_cfg, o_supply_cfg, m_osc, m_sup);
        else n_pass++;
        low_ready = 0;
        repeat (8) begin
            @(negedge clk);
            if (!wr.write_ready || o_scan_en) low_ready++;
        end
        n_checks++; if (low_ready !== 0) $display("FAIL busy_single_accept got %0d busy cycles want 0", low_ready); else n_pass++;
    endtask

    task automatic test_random();
        int lat, bad, rises, hi, fh;
        logic [11:0] a;
        logic [168:0] p;
        for (int r = 0; r < 40; r++) begin
            a = 12'($urandom_range(1, 3));
            p = rand_pl();
            do_write(1'b0, a, p, 1'($urandom_range(0, 1)), lat, bad, rises, hi, fh);
            model_write(1'b0, a, p);
            n_checks++; if (lat !== LAT_SHIFT || bad !== 0)
                $display("FAIL rand%0d_timing got lat %0d bad %0d want lat %0d bad 0", r, lat, bad, LAT_SHIFT);
            else n_pass++;
            n_checks++; if (o_osc_cfg !== m_osc) $display("FAIL rand%0d_osc got %h want %h", r, o_osc_cfg, m_osc); else n_pass++;
            n_checks++; if (o_rf_cfg !== m_rf) $display("FAIL rand%0d_rf got %h want %h", r, o_rf_cfg, m_rf); else n_pass++;
            n_checks++; if (o_supply_cfg !== m_sup) $display("FAIL rand%0d_sup got %h want %h", r, o_supply_cfg, m_sup); else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_abort();
        wr.write_valid = 1'b1; wr.write_reset = 1'b0; wr.write_addr = 12'd1; wr.write_payload = rand_pl();
        @(posedge clk);
        @(negedge clk);
        wr.write_valid = 1'b0;
        repeat (300) @(negedge clk);
        n_checks++; if (o_scan_en !== 1'b1) $display("FAIL abort_busy got scan_en %b want 1", o_scan_en); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_scan_clk, o_scan_en, o_scan_in, o_scan_reset, o_scan_out} !== 5'b0)
            $display("FAIL abort_pins got %b want 00000", {o_scan_clk, o_scan_en, o_scan_in, o_scan_reset, o_scan_out});
        else n_pass++;
        n_checks++; if ({o_osc_cfg, o_rf_cfg, o_supply_cfg} !== '0) $display("FAIL abort_cfg got nonzero want 0"); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (wr.write_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", wr.write_ready); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_txn();
        test_supply();
        test_osc_hold();
        test_rf();
        test_bad_addr_busy();
        test_random();
        test_reset_txn();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
